// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the fetch sequencer: widths, reset PC and FSM encoding.
package fetch_defs;

   localparam int          ADDR_W   = 32;
   localparam int          INSTR_W  = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   // Instruction addresses are word aligned; the two low bits never reach memory.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, instr}: entry 0 is the output register, entry 1 the skid.
module fetch_skid_buf #(
   parameter int ADDR_W  = fetch_defs::ADDR_W,
   parameter int INSTR_W = fetch_defs::INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   input  logic               flush,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [1:0]         count,
   output logic               full
);
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t entry0, entry1, new_entry;
   logic   do_push, do_pop;

   assign new_entry  = '{pc: push_pc, instr: push_instr};
   assign full       = (count == 2'd2);
   assign do_pop     = pop && (count != 2'd0);
   assign do_push    = push && (!full || do_pop);
   assign head_pc    = entry0.pc;
   assign head_instr = entry0.instr;

   // NOTE: non-blocking assignments for every register so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) count <= 2'd0;
      else              count <= count + {1'b0, do_push} - {1'b0, do_pop};
   end

   // NOTE: payload storage is deliberately not reset; validity lives only in count,
   // and the top gates the visible outputs with it.
   always_ff @(posedge clk) begin
      if (!flush) begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) entry0 <= new_entry;
               else               entry1 <= new_entry;
            end
            2'b01: entry0 <= entry1;
            2'b11: begin
               if (count == 2'd1) begin
                  entry0 <= new_entry;
               end else begin
                  entry0 <= entry1;
                  entry1 <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// PC sequencer and instruction-fetch controller with a two-entry queue toward decode.
// Optional FETCH_STATS_EN adds saturating fetch and bubble counters.
module fetch_seq #(
   parameter int                ADDR_W   = fetch_defs::ADDR_W,
   parameter int                INSTR_W  = fetch_defs::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_defs::RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  pc_next_in,
   input  logic               stall,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        stat_fetch,
   output logic [31:0]        stat_bubble
`endif
);
   import fetch_defs::*;

   fetch_state_e      state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, abort_addr, abort_n, target;
   logic              push, pop, flush;
   logic [1:0]        q_count;
   logic              q_full;
   logic [ADDR_W-1:0] head_pc;
   logic [INSTR_W-1:0] head_instr;

   assign target      = {pc_next_in[ADDR_W-1:2], 2'b00};
   assign instr_valid = (q_count != 2'd0);
   assign pop         = instr_valid && !stall;
   assign instr       = instr_valid ? head_instr : '0;
   assign instr_pc    = instr_valid ? head_pc    : '0;
   // While draining, the aborted address must stay on the bus until its ack.
   assign imem_addr   = (state == DRAIN) ? abort_addr : pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         abort_addr <= RESET_PC;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         abort_addr <= abort_n;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      abort_n  = abort_addr;
      push     = 1'b0;
      flush    = 1'b0;
      imem_req = 1'b0;
      unique case (state)
         IDLE: begin
            state_n = FETCH;
            if (redirect) begin
               flush = 1'b1;
               pc_n  = target;
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               flush = 1'b1;
               pc_n  = target;
               if (!imem_ack) begin
                  abort_n = pc;
                  state_n = DRAIN;
               end
            end else if (imem_ack) begin
               push = 1'b1;
               pc_n = pc + ADDR_W'(4);
               // Holding two words after this edge means no room for another request.
               if (q_count == 2'd1 && !pop) state_n = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               flush   = 1'b1;
               pc_n    = target;
               state_n = FETCH;
            end else if (pop || !q_full) begin
               state_n = FETCH;
            end
         end
         DRAIN: begin
            imem_req = 1'b1;
            if (redirect) begin
               flush = 1'b1;
               pc_n  = target;
            end
            if (imem_ack) state_n = FETCH;
         end
         default: state_n = IDLE;
      endcase
   end

   fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .INSTR_W(INSTR_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_pc   (pc),
      .push_instr(imem_rdata),
      .pop       (pop),
      .flush     (flush),
      .head_pc   (head_pc),
      .head_instr(head_instr),
      .count     (q_count),
      .full      (q_full)
   );

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetch  <= '0;
         stat_bubble <= '0;
      end else begin
         if (push && stat_fetch != '1)         stat_fetch  <= stat_fetch + 32'd1;
         if (!instr_valid && stat_bubble != '1) stat_bubble <= stat_bubble + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_seq;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst, redirect, stall, imem_ack;
   logic [31:0] pc_next_in, imem_rdata;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, instr_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetch, stat_bubble;
`endif

   always #5 clk = ~clk;

   fetch_seq #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .pc_next_in (pc_next_in),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetch (stat_fetch),
      .stat_bubble(stat_bubble)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } fetched_t;

   fetched_t    m_q[$];
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_drop, m_start;
   logic [31:0] m_fetch, m_bubble;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
   endfunction

   // One clock edge of the fetch unit, stated in terms of requests and a word queue.
   task automatic model_step(input bit r, input bit redir, input logic [31:0] tgt,
                             input bit stl, input bit ack, input logic [31:0] rdata);
      bit pop;
      if (r) begin
         m_q.delete();
         m_pc = RST_PC; m_addr = RST_PC;
         m_req = 0; m_drop = 0; m_start = 1;
         m_fetch = 0; m_bubble = 0;
         return;
      end
      if (m_q.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      pop = (m_q.size() != 0) && !stl;
      if (redir) begin
         m_q.delete();
         m_pc = {tgt[31:2], 2'b00};
         m_start = 0;
         if (!m_req || ack) begin
            m_req = 1; m_addr = m_pc; m_drop = 0;
         end else begin
            m_drop = 1;
         end
      end else if (m_req && ack) begin
         if (pop) void'(m_q.pop_front());
         if (m_drop) begin
            m_drop = 0;
            m_addr = m_pc;
         end else begin
            m_q.push_back('{pc: m_addr, word: rdata});
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
            m_pc = m_pc + 32'd4;
            if (m_q.size() == 2) m_req = 0;
            else m_addr = m_pc;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (!m_req && (m_start || pop)) begin
            m_start = 0;
            m_req = 1; m_addr = m_pc;
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] e_pc, e_word;
      e_pc = 0; e_word = 0;
      if (m_q.size() != 0) begin
         e_pc = m_q[0].pc; e_word = m_q[0].word;
      end
      check("imem_req", 32'(imem_req), 32'(m_req));
      check("imem_addr", imem_addr, m_req ? m_addr : m_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
      check("instr_pc", instr_pc, e_pc);
      check("instr", instr, e_word);
`ifdef FETCH_STATS_EN
      check("stat_fetch", stat_fetch, m_fetch);
      check("stat_bubble", stat_bubble, m_bubble);
`endif
   endtask

   // ---------------- memory responder and clocking ----------------
   int ack_lat   = 0;
   int ack_pct   = 100;
   int lat_cnt   = 0;
   bit ack_force = 0;

   task automatic tick();
      if (ack_force) imem_ack = 1'b1;
      else imem_ack = m_req && (lat_cnt >= ack_lat) && ($urandom_range(99) < ack_pct);
      imem_rdata = m_req ? mem_word(m_addr) : $urandom;
      if (m_req && !imem_ack && !rst) lat_cnt++;
      else lat_cnt = 0;
      model_step(rst, redirect, pc_next_in, stall, imem_ack, imem_rdata);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; stall = 1'b0; ack_force = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] seen[$];
   bit          got_valid;

   initial begin
      pc_next_in = '0; imem_ack = 1'b0; imem_rdata = '0;
      @(negedge clk);

      // Zero-latency memory streams one word per cycle from RESET_PC.
      do_reset();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_addr", imem_addr, RST_PC);
      tick();
      check("s1_req", 32'(imem_req), 32'd1);
      check("s1_addr0", imem_addr, 32'h3000);
      tick();
      check("s1_addr1", imem_addr, 32'h3004);
      check("s1_valid", 32'(instr_valid), 32'd1);
      check("s1_pc0", instr_pc, 32'h3000);
      tick();
      check("s1_addr2", imem_addr, 32'h3008);
      check("s1_pc1", instr_pc, 32'h3004);

      // Stall fills the queue with exactly two words, then nothing is lost on release.
      do_reset();
      stall = 1'b1;
      repeat (5) tick();
      check("s2_req_off", 32'(imem_req), 32'd0);
      check("s2_head", instr_pc, 32'h3000);
      stall = 1'b0;
      seen.delete();
      for (int i = 0; i < 20 && seen.size() < 3; i++) begin
         if (instr_valid) seen.push_back(instr_pc);
         tick();
      end
      check("s2_count", seen.size(), 3);
      for (int i = 0; i < seen.size(); i++)
         check("s2_order", seen[i], 32'h3000 + 32'(4 * i));

      // Redirect while a slow request is outstanding: old request drains, data dropped.
      do_reset();
      ack_lat = 3;
      tick();
      tick();
      redirect = 1'b1; pc_next_in = 32'h4000;
      tick();
      redirect = 1'b0;
      check("s3_hold_addr", imem_addr, 32'h3000);
      check("s3_hold_req", 32'(imem_req), 32'd1);
      got_valid = 0;
      for (int i = 0; i < 30 && !got_valid; i++) begin
         tick();
         if (instr_valid) got_valid = 1;
      end
      check("s3_got_valid", 32'(got_valid), 32'd1);
      check("s3_first_pc", instr_pc, 32'h4000);

      // Redirect coincident with an ack flushes the queue.
      do_reset();
      ack_lat = 0;
      stall = 1'b1;
      tick();
      tick();
      redirect = 1'b1; pc_next_in = 32'h5000;
      tick();
      redirect = 1'b0; stall = 1'b0;
      check("s4_flush", 32'(instr_valid), 32'd0);
      check("s4_addr", imem_addr, 32'h5000);

      // PC wraps at the top of the address space; redirect targets are word aligned.
      redirect = 1'b1; pc_next_in = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("s5_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("s5_wrap", imem_addr, 32'h0000_0000);
      redirect = 1'b1; pc_next_in = 32'h0000_1003;
      tick();
      redirect = 1'b0;
      check("s5_align", imem_addr, 32'h0000_1000);

      // Reset in the middle of a drain; a stale ack afterwards is ignored.
      do_reset();
      ack_lat = 3;
      tick();
      redirect = 1'b1; pc_next_in = 32'h6000;
      tick();
      redirect = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s6_req", 32'(imem_req), 32'd0);
      check("s6_valid", 32'(instr_valid), 32'd0);
      ack_force = 1;
      tick();
      ack_force = 0;
      check("s6_restart", imem_addr, RST_PC);
      check("s6_restart_req", 32'(imem_req), 32'd1);

      // Randomized traffic against the model.
      ack_lat = 0; ack_pct = 100;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 500 == 0) begin
            ack_lat = $urandom_range(3);
            ack_pct = 50 + $urandom_range(50);
         end
         rst      = ($urandom_range(299) == 0);
         redirect = ($urandom_range(15) == 0);
         stall    = ($urandom_range(2) == 0);
         if ($urandom_range(7) == 0) pc_next_in = 32'hFFFF_FFF0 + $urandom_range(15);
         else                        pc_next_in = $urandom;
         tick();
      end
      rst = 1'b0; redirect = 1'b0; stall = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
